hv_mem_arbiter: RTL and testbench
=================================

// Module: hv_mem_arbiter
// PURPOSE
//  Shares one single-cycle-latency HV RAM port among NUM_REQ requesters (encoders, bundlers, similarity units).
//  Round-robin arbitration with an optional per-requester lock for bursts; one access issued per cycle max.
//  Registered command stage drives the RAM; read data is returned to the issuing requester, tagged one-hot.
//  Sits between HDC compute blocks and the DP RAM (single port, NUM_PORTS=1).
// PARAMETERS
//  NUM_REQ          4   number of requesters (>=2)
//  HV_DATA_WIDTH    32  RAM word width
//  HV_ADDRESS_WIDTH 21  RAM address width
// PORTS
//  clk          in  1                    clock, all state on rising edge
//  reset_n      in  1                    asynchronous active-low reset
//  req_valid    in  NUM_REQ              request pending, per requester
//  req_ready    out NUM_REQ              grant; transfer when valid&ready
//  req_we       in  NUM_REQ              1=write, 0=read
//  req_lock     in  NUM_REQ              hold grant after this transfer (burst)
//  req_address  in  [AW-1:0] x NUM_REQ   unpacked array [0:NUM_REQ-1]
//  req_data     in  [DW-1:0] x NUM_REQ   write data, unpacked array
//  rsp_valid    out NUM_REQ              one-hot 1-cycle pulse: read data valid for that requester
//  rsp_data     out DW                   read data, shared bus
//  mem_we_n     out 1                    to RAM we_n (active-low)
//  mem_address  out AW                   to RAM address
//  mem_wdata    out DW                   to RAM data_i
//  mem_rdata    in  DW                   from RAM data_o (valid 1 cycle after address sampled)
// BEHAVIOUR
//  Reset: req_ready=0, rsp_valid=0, rsp_data=0, mem_we_n=1, mem_address=0, mem_wdata=0; RR pointer favours req 0; FSM=ARB; pipeline empty.
//  req_ready combinational from req_valid and state; at most one bit set; never asserted during reset.
//  FSM ARB: grant = first valid requester at or after (last_grant+1) mod NUM_REQ; if none, req_ready=0.
//    Transfer with req_lock[g]=1 -> LOCK(g); otherwise stay ARB, last_grant<=g.
//  FSM LOCK(g): req_ready = one-hot g gated by req_valid[g]; other requesters stalled.
//    Transfer with req_lock[g]=0 -> ARB, last_grant<=g. req_valid[g] low: stay LOCK (bubble allowed).
//  Issue stage (cycle T = transfer): at T+1 mem_address/mem_wdata=captured values, mem_we_n=~we, tag=g, rd flag=~we.
//  Idle cycle at T+1: mem_we_n=1, mem_address/mem_wdata hold previous value (no spurious write).
//  Read latency: RAM samples at end of T+1, mem_rdata valid T+2; rsp_valid[g]=1 and rsp_data=mem_rdata registered at T+3.
//  Writes produce no response; rsp_data holds last value when rsp_valid=0.
//  Throughput: one transfer per cycle back-to-back; no backpressure on responses (requester must accept).
//  Ordering: accesses hit RAM in grant order; write at T then read same address at T+1 returns new data.
//  Simultaneous req_valid all high, no lock: grants rotate 0,1,2,3,0... one per cycle.
//  req_valid deasserted mid-ARB: no grant, no state change; RR pointer moves only on transfer.
//  Reset mid-operation: in-flight accesses and pending responses discarded, FSM->ARB, outputs to reset values.
//  Widths: tag = $clog2(NUM_REQ) bits; pointer arithmetic wraps modulo NUM_REQ (non-power-of-two supported).
// STRUCTURE
//  Package hv_mem_pkg: addr_t, data_t typedefs (from parameters), arb_state_e {ARB, LOCK}, function
//    onehot_to_idx; shared with other HV memory clients.
//  Sub-module hv_rr_arbiter: NUM_REQ request vector + pointer -> one-hot grant, purely combinational.
//  Top: FSM + lock owner reg, issue-stage regs, 2-deep read tag pipeline, response reg.
// TESTING  (NUM_REQ=4, DW=32, AW=21, against the single-port RAM emulator)
//  Reset: reset_n=0 -> all outputs at reset values, mem_we_n=1; release, no requests -> mem_we_n stays 1.
//  Req1 write addr 0x10 data 0xDEADBEEF at T, req1 read 0x10 at T+1 -> rsp_valid=4'b0010, rsp_data=0xDEADBEEF at T+4.
//  All 4 valid reads (addr=k) for 8 cycles -> grants 0,1,2,3,0,1,2,3; rsp_valid one-hot in same order, 3 cycles after each.
//  Req2 lock for 3 transfers while req0/3 valid -> req_ready=4'b0100 for 3 transfers, then req3 next (RR after 2).
//  Req0 read 0x1F_FFFF (top addr) then 0x0 -> correct data, no aliasing; idle cycles show mem_we_n=1.
//  Assert reset_n=0 with 2 reads in flight -> no rsp_valid after release; FSM ARB; first grant goes to req 0.

Source files
------------

// File: rtl/hv_mem_pkg.sv
// ----------------------------------------------------------------------------
// hv_mem_pkg
//   Types and helpers shared by the HV memory clients and the HV RAM arbiter.
//   addr_t / data_t  : default-width HV RAM address and data words
//   arb_state_e      : arbiter FSM states (ARB = round-robin, LOCK = burst hold)
//   onehot_to_idx    : index of the set bit of a one-hot vector (up to 32 bits)
// ----------------------------------------------------------------------------
package hv_mem_pkg;

    localparam int HV_DATA_WIDTH_DEFAULT    = 32;
    localparam int HV_ADDRESS_WIDTH_DEFAULT = 21;

    typedef logic [HV_ADDRESS_WIDTH_DEFAULT-1:0] addr_t;
    typedef logic [HV_DATA_WIDTH_DEFAULT-1:0]    data_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Returns 0 for an all-zero vector; callers only use it on a valid grant.
    function automatic int unsigned onehot_to_idx(input logic [31:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (oh[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hv_rr_arbiter.sv
// ----------------------------------------------------------------------------
// hv_rr_arbiter
//   Purely combinational round-robin pick: grants the first set request bit
//   at or after position ptr, wrapping modulo NUM_REQ.
//   req   in  NUM_REQ           request vector
//   ptr   in  $clog2(NUM_REQ)   highest-priority position (0..NUM_REQ-1)
//   grant out NUM_REQ           one-hot grant, zero when no request
// ----------------------------------------------------------------------------
module hv_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // modulo keeps the scan valid for non-power-of-two NUM_REQ
            idx = PTR_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hv_mem_arbiter.sv
// ----------------------------------------------------------------------------
// hv_mem_arbiter
//   Shares one single-cycle-latency HV RAM port among NUM_REQ requesters with
//   round-robin arbitration and an optional per-requester burst lock. One
//   access is issued per cycle through a registered command stage; read data
//   returns three cycles after the transfer, tagged one-hot to the issuer.
//   clk, reset_n             clock / asynchronous active-low reset
//   req_valid/ready/we/lock  per-requester handshake, direction, burst hold
//   req_address, req_data    per-requester address / write data
//   rsp_valid, rsp_data      one-hot read-return pulse and shared data bus
//   mem_we_n, mem_address,
//   mem_wdata, mem_rdata     single-port RAM interface
// ----------------------------------------------------------------------------
module hv_mem_arbiter #(
    parameter int NUM_REQ          = 4,
    parameter int HV_DATA_WIDTH    = 32,
    parameter int HV_ADDRESS_WIDTH = 21
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ-1:0]          req_lock,
    input  logic [HV_ADDRESS_WIDTH-1:0] req_address [0:NUM_REQ-1],
    input  logic [HV_DATA_WIDTH-1:0]    req_data    [0:NUM_REQ-1],
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [HV_DATA_WIDTH-1:0]    rsp_data,
    output logic                        mem_we_n,
    output logic [HV_ADDRESS_WIDTH-1:0] mem_address,
    output logic [HV_DATA_WIDTH-1:0]    mem_wdata,
    input  logic [HV_DATA_WIDTH-1:0]    mem_rdata
);

    import hv_mem_pkg::*;

    localparam int TAG_W = $clog2(NUM_REQ);

    arb_state_e         state, state_nxt;
    logic [TAG_W-1:0]   lock_owner, lock_owner_nxt;
    logic [TAG_W-1:0]   last_grant, last_grant_nxt;
    logic [TAG_W-1:0]   rr_ptr, g_idx;
    logic [NUM_REQ-1:0] rr_grant, lock_oh, grant;
    logic               fire;

    logic [TAG_W-1:0]   tag_p0, tag_p1;
    logic               rd_p0, rd_p1;
    logic [NUM_REQ-1:0] rsp_oh;

    assign rr_ptr = (last_grant == TAG_W'(NUM_REQ - 1)) ? '0 : last_grant + TAG_W'(1);

    hv_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant)
    );

    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        last_grant_nxt = last_grant;
        lock_oh        = '0;
        lock_oh[lock_owner] = 1'b1;
        grant          = '0;
        case (state)
            ARB:     grant = rr_grant;
            LOCK:    grant = lock_oh & req_valid;
            default: grant = '0;
        endcase
        // req_ready must stay low while reset is held, even with req_valid high
        if (!reset_n) begin
            grant = '0;
        end
        fire  = |grant;
        g_idx = TAG_W'(onehot_to_idx(32'(grant)));
        if (fire) begin
            last_grant_nxt = g_idx;
            if (req_lock[g_idx]) begin
                state_nxt      = LOCK;
                lock_owner_nxt = g_idx;
            end else begin
                state_nxt = ARB;
            end
        end
        req_ready = grant;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB;
            lock_owner <= '0;
            last_grant <= TAG_W'(NUM_REQ - 1);  // next pick favours requester 0
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // ---- stage p0: issue registers drive the RAM (T+1) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_we_n    <= 1'b1;
            mem_address <= '0;
            mem_wdata   <= '0;
            tag_p0      <= '0;
            rd_p0       <= 1'b0;
        end else if (fire) begin
            mem_we_n    <= ~req_we[g_idx];
            mem_address <= req_address[g_idx];
            mem_wdata   <= req_data[g_idx];
            tag_p0      <= g_idx;
            rd_p0       <= ~req_we[g_idx];
        end else begin
            // address/data hold so an idle cycle never looks like a new access
            mem_we_n <= 1'b1;
            rd_p0    <= 1'b0;
        end
    end

    // ---- stage p1: tag aligned with mem_rdata (T+2) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_p1 <= '0;
            rd_p1  <= 1'b0;
        end else begin
            tag_p1 <= tag_p0;
            rd_p1  <= rd_p0;
        end
    end

    always_comb begin
        rsp_oh         = '0;
        rsp_oh[tag_p1] = 1'b1;
    end

    // ---- response register (T+3) ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= rd_p1 ? rsp_oh : '0;
            if (rd_p1) begin
                rsp_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_hv_mem_arbiter.sv
module tb_hv_mem_arbiter;

    import hv_mem_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [3:0]  req_valid, req_ready, req_we, req_lock;
    logic [20:0] req_address [0:3];
    logic [31:0] req_data    [0:3];
    logic [3:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        mem_we_n;
    logic [20:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    hv_mem_arbiter #(
        .NUM_REQ          (4),
        .HV_DATA_WIDTH    (32),
        .HV_ADDRESS_WIDTH (21)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_lock    (req_lock),
        .req_address (req_address),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .mem_we_n    (mem_we_n),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // single-port RAM emulator: synchronous read of the sampled address
    data_t ram [addr_t];
    always @(posedge clk) begin
        mem_rdata <= ram.exists(mem_address) ? ram[mem_address] : 32'h0;
        if (!mem_we_n) ram[mem_address] = mem_wdata;
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct { int due; int g; logic [31:0] d; } rsp_t;
    rsp_t        rspq [$];
    bit [31:0]   mdl_mem [bit [20:0]];
    int          cyc;
    int          m_ptr;
    int          m_lock;
    logic        exp_we_n;
    logic [20:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;

    task automatic model_reset();
        rspq.delete();
        m_ptr     = 0;
        m_lock    = -1;
        exp_we_n  = 1'b1;
        exp_addr  = '0;
        exp_wdata = '0;
        exp_rdata = '0;
    endtask

    function automatic int mdl_grant(input logic [3:0] v);
        if (m_lock >= 0) return v[m_lock] ? m_lock : -1;
        for (int i = 0; i < 4; i++) begin
            if (v[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    // Called right after a falling edge with inputs already driven.
    task automatic step(input bit tab, input logic [3:0] t_ready,
                        input logic [3:0] t_rv, input logic [31:0] t_rd);
        int         g;
        logic [3:0] exp_ready, exp_rv;
        #1;
        g         = mdl_grant(req_valid);
        exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        exp_rv    = 4'b0000;
        if (rspq.size() > 0 && rspq[0].due == cyc) begin
            exp_rv    = 4'b0001 << rspq[0].g;
            exp_rdata = rspq[0].d;
            void'(rspq.pop_front());
        end
        chk("req_ready", req_ready, exp_ready);
        chk("mem_we_n", mem_we_n, exp_we_n);
        chk("mem_address", mem_address, exp_addr);
        chk("mem_wdata", mem_wdata, exp_wdata);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_data", rsp_data, exp_rdata);
        if (tab) begin
            chk("tab_ready", req_ready, t_ready);
            chk("tab_rsp_valid", rsp_valid, t_rv);
            if (t_rv != 4'b0000) chk("tab_rsp_data", rsp_data, t_rd);
        end
        if (g >= 0) begin
            exp_we_n  = ~req_we[g];
            exp_addr  = req_address[g];
            exp_wdata = req_data[g];
            if (req_we[g]) mdl_mem[req_address[g]] = req_data[g];
            else rspq.push_back('{cyc + 3, g,
                     mdl_mem.exists(req_address[g]) ? mdl_mem[req_address[g]] : 32'h0});
            m_lock = req_lock[g] ? g : -1;
            m_ptr  = (g + 1) % 4;
        end else begin
            exp_we_n = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [3:0]       valid, we, lock;
        logic [3:0][20:0] addr;
        logic [3:0][31:0] data;
        logic [3:0]       exp_ready, exp_rv;
        logic [31:0]      exp_rd;
    } vec_t;

    vec_t vecs [32];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] we, input logic [3:0] lk,
                                input logic [20:0] a, input logic [31:0] d,
                                input logic [3:0] rdy, input logic [3:0] rv, input logic [31:0] rd);
        vec_t r;
        r.valid = v; r.we = we; r.lock = lk;
        for (int k = 0; k < 4; k++) begin
            r.addr[k] = a;
            r.data[k] = d;
        end
        r.exp_ready = rdy; r.exp_rv = rv; r.exp_rd = rd;
        return r;
    endfunction

    task automatic drive_idle();
        req_valid = '0; req_we = '0; req_lock = '0;
        for (int k = 0; k < 4; k++) begin
            req_address[k] = '0;
            req_data[k]    = '0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            ram[21'(k)]     = 32'hA000_0000 + k;
            mdl_mem[21'(k)] = 32'hA000_0000 + k;
        end
        // all four requesters read addr=k, rotating grants 0,1,2,3,0,1,2,3
        vecs[0]  = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0000, 32'h0);
        vecs[1]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0001, 4'b0000, 32'h0);
        vecs[2]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0010, 4'b0000, 32'h0);
        vecs[3]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0100, 4'b0000, 32'h0);
        vecs[4]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b1000, 4'b0001, 32'hA000_0000);
        vecs[5]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0001, 4'b0010, 32'hA000_0001);
        vecs[6]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0010, 4'b0100, 32'hA000_0002);
        vecs[7]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0100, 4'b1000, 32'hA000_0003);
        vecs[8]  = mk(4'hF, 4'h0, 4'h0, 21'h0, 32'h0, 4'b1000, 4'b0001, 32'hA000_0000);
        for (int i = 1; i <= 8; i++)
            for (int k = 0; k < 4; k++) vecs[i].addr[k] = 21'(k);
        vecs[9]  = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0010, 32'hA000_0001);
        vecs[10] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0100, 32'hA000_0002);
        vecs[11] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b1000, 32'hA000_0003);
        // req1 write then read-after-write of 0x10
        vecs[12] = mk(4'b0010, 4'b0010, 4'h0, 21'h10, 32'hDEAD_BEEF, 4'b0010, 4'b0000, 32'h0);
        vecs[13] = mk(4'b0010, 4'b0000, 4'h0, 21'h10, 32'h0,         4'b0010, 4'b0000, 32'h0);
        vecs[14] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0000, 32'h0);
        vecs[15] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0000, 32'h0);
        vecs[16] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0010, 32'hDEAD_BEEF);
        // req2 burst lock (3 transfers, one bubble) while req0/req3 wait
        vecs[17] = mk(4'b1101, 4'h0, 4'b0100, 21'h10, 32'h0, 4'b0100, 4'b0000, 32'h0);
        vecs[18] = mk(4'b1001, 4'h0, 4'b0000, 21'h10, 32'h0, 4'b0000, 4'b0000, 32'h0);
        vecs[19] = mk(4'b1101, 4'h0, 4'b0100, 21'h10, 32'h0, 4'b0100, 4'b0000, 32'h0);
        vecs[20] = mk(4'b1101, 4'h0, 4'b0000, 21'h10, 32'h0, 4'b0100, 4'b0100, 32'hDEAD_BEEF);
        vecs[21] = mk(4'b1001, 4'h0, 4'b0000, 21'h10, 32'h0, 4'b1000, 4'b0000, 32'h0);
        vecs[22] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0100, 32'hDEAD_BEEF);
        vecs[23] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0100, 32'hDEAD_BEEF);
        vecs[24] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b1000, 32'hDEAD_BEEF);
        // top and bottom address, no aliasing
        vecs[25] = mk(4'b0001, 4'b0001, 4'h0, 21'h1F_FFFF, 32'h1357_2468, 4'b0001, 4'b0000, 32'h0);
        vecs[26] = mk(4'b0001, 4'b0001, 4'h0, 21'h0,       32'h2468_ACE0, 4'b0001, 4'b0000, 32'h0);
        vecs[27] = mk(4'b0001, 4'b0000, 4'h0, 21'h1F_FFFF, 32'h0, 4'b0001, 4'b0000, 32'h0);
        vecs[28] = mk(4'b0001, 4'b0000, 4'h0, 21'h0,       32'h0, 4'b0001, 4'b0000, 32'h0);
        vecs[29] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0000, 32'h0);
        vecs[30] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0001, 32'h1357_2468);
        vecs[31] = mk(4'h0, 4'h0, 4'h0, 21'h0, 32'h0, 4'b0000, 4'b0001, 32'h2468_ACE0);

        // ---- reset state ----
        cyc = 0;
        model_reset();
        drive_idle();
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_rsp_valid", rsp_valid, 4'b0000);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_mem_we_n", mem_we_n, 1'b1);
        chk("rst_mem_address", mem_address, 21'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        req_valid = 4'h0;
        reset_n   = 1'b1;
        @(negedge clk);

        // ---- table ----
        for (int i = 0; i < 32; i++) begin
            req_valid = vecs[i].valid;
            req_we    = vecs[i].we;
            req_lock  = vecs[i].lock;
            for (int k = 0; k < 4; k++) begin
                req_address[k] = vecs[i].addr[k];
                req_data[k]    = vecs[i].data[k];
            end
            step(1'b1, vecs[i].exp_ready, vecs[i].exp_rv, vecs[i].exp_rd);
        end

        // ---- reset with two reads in flight ----
        drive_idle();
        req_valid = 4'b0110;
        for (int k = 0; k < 4; k++) req_address[k] = 21'h10;
        step(1'b0, 4'h0, 4'h0, 32'h0);
        step(1'b0, 4'h0, 4'h0, 32'h0);
        reset_n   = 1'b0;
        req_valid = 4'hF;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("midrst_req_ready", req_ready, 4'b0000);
            chk("midrst_rsp_valid", rsp_valid, 4'b0000);
            chk("midrst_mem_we_n", mem_we_n, 1'b1);
            chk("midrst_mem_address", mem_address, 21'h0);
            @(negedge clk);
        end
        model_reset();
        req_valid = 4'h0;
        reset_n   = 1'b1;
        for (int c = 0; c < 5; c++) step(1'b1, 4'b0000, 4'b0000, 32'h0);
        req_valid = 4'hF;
        step(1'b1, 4'b0001, 4'b0000, 32'h0);
        drive_idle();
        for (int c = 0; c < 4; c++) step(1'b0, 4'h0, 4'h0, 32'h0);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            req_we    = 4'($urandom);
            req_lock  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            for (int k = 0; k < 4; k++) begin
                req_address[k] = ($urandom_range(0, 7) == 0) ? 21'($urandom)
                                                             : 21'($urandom_range(0, 15));
                req_data[k]    = $urandom;
            end
            step(1'b0, 4'h0, 4'h0, 32'h0);
        end
        drive_idle();
        for (int c = 0; c < 5; c++) step(1'b0, 4'h0, 4'h0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
